// File: rtl/bank_read_sequencer_pkg.sv
// Shared definitions for the bank read sequencer and the four-bank byte mux
// that sits beside it at the next level up.
package bank_read_sequencer_pkg;

  localparam int ADDR_W = 4;
  localparam int BANK_W = 2;
  localparam int BYTE_W = 2;
  localparam int LEN_W  = 5;
  localparam int DATA_W = 8;
  localparam int NUM_BANKS      = 4;
  localparam int BYTES_PER_BANK = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  // Byte addresses wrap modulo 16, so bank 3 byte 3 is followed by bank 0 byte 0.
  function automatic logic [ADDR_W-1:0] nextAddr(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/bank_byte_mux.sv
// Four-bank byte mux: combinationally returns one byte for a bank/byte select,
// byte 0 being the least significant byte of each bank word.
module bank_byte_mux
  import bank_read_sequencer_pkg::*;
(
  input  logic [NUM_BANKS-1:0][BYTES_PER_BANK-1:0][DATA_W-1:0] banks_i,
  input  logic [BANK_W-1:0]                                    bank_sel_i,
  input  logic [BYTE_W-1:0]                                    byte_sel_i,
  output logic [DATA_W-1:0]                                    data_o
);

  assign data_o = banks_i[bank_sel_i][byte_sel_i];

endmodule

// File: rtl/bank_read_sequencer.sv
// Walks a burst of byte addresses through an external four-bank mux and
// presents each byte downstream with a valid/ready handshake.
module bank_read_sequencer
  import bank_read_sequencer_pkg::*;
(
  input  logic              wb_clk_i,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  output logic [BANK_W-1:0] bank_sel,
  output logic [BYTE_W-1:0] byte_sel,
  input  logic [DATA_W-1:0] mux_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic [DATA_W-1:0] outData_q, outData_d;
  logic              outValid_q, outValid_d;

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      outData_q  <= '0;
      outValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      outData_q  <= outData_d;
      outValid_q <= outValid_d;
    end
  end

  // Abort is applied last so it overrides any handshake in the same cycle.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    outData_d  = outData_q;
    outValid_d = outValid_q;

    unique case (state_q)
      IDLE: begin
        if (start && !abort && (len != '0)) begin
          addr_d   = start_addr;
          remain_d = len;
          state_d  = FETCH;
        end
      end
      FETCH: begin
        outData_d  = mux_data;
        outValid_d = 1'b1;
        state_d    = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          outValid_d = 1'b0;
          if (remain_q == LEN_W'(1)) begin
            state_d = DONE;
          end else begin
            remain_d = remain_q - LEN_W'(1);
            addr_d   = nextAddr(addr_q);
            state_d  = FETCH;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      addr_d     = addr_q;
      remain_d   = remain_q;
      outData_d  = outData_q;
      outValid_d = 1'b0;
    end
  end

  assign bank_sel  = addr_q[ADDR_W-1 -: BANK_W];
  assign byte_sel  = addr_q[BYTE_W-1:0];
  assign out_data  = outData_q;
  assign out_valid = outValid_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_bank_read_sequencer.sv
// Directed bench for bank_read_sequencer: expected bytes are queued when a
// burst is started and popped as each handshake completes.
module tb_bank_read_sequencer;
  import bank_read_sequencer_pkg::*;

  logic              wb_clk_i;
  logic              rst_n;
  logic              start;
  logic [3:0]        start_addr;
  logic [4:0]        len;
  logic              abort;
  logic [1:0]        bank_sel;
  logic [1:0]        byte_sel;
  logic [7:0]        mux_data;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic [3:0][3:0][7:0] banks;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } expT;

  expT        sb[$];
  int         passCount  = 0;
  int         totalCount = 0;
  int         cyc        = 0;
  int         startCyc   = 0;
  logic [31:0] bankWords [4];
  logic [7:0]  heldData;
  logic [3:0]  heldSel;

  bank_read_sequencer dut (
    .wb_clk_i   (wb_clk_i),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .len        (len),
    .abort      (abort),
    .bank_sel   (bank_sel),
    .byte_sel   (byte_sel),
    .mux_data   (mux_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done)
  );

  bank_byte_mux mux (
    .banks_i    (banks),
    .bank_sel_i (bank_sel),
    .byte_sel_i (byte_sel),
    .data_o     (mux_data)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  function automatic logic [7:0] modelByte(input int a);
    logic [31:0] w;
    w = bankWords[(a >> 2) & 3];
    return w[8*(a & 3) +: 8];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, observed, expected, cyc);
  endtask

  task automatic tick();
    @(negedge wb_clk_i);
    cyc++;
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic [4:0] l);
    start      = 1'b1;
    start_addr = a;
    len        = l;
    for (int i = 0; i < l; i++) begin
      expT e;
      e.addr = 4'((int'(a) + i) % 16);
      e.data = modelByte((int'(a) + i) % 16);
      sb.push_back(e);
    end
    startCyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic drainBurst(input int n, input bit checkTiming);
    int handshakes;
    int budget;
    expT e;
    handshakes = 0;
    budget     = 200;
    while (handshakes < n && budget > 0) begin
      if (out_valid && out_ready) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checkOutput("data", 32'(out_data), 32'(e.data));
          checkOutput("sel", 32'({bank_sel, byte_sel}), 32'(e.addr));
        end else begin
          checkOutput("scoreboardEmpty", 32'(1), 32'(0));
        end
        if (checkTiming)
          checkOutput("validCycle", 32'(cyc - startCyc), 32'(2 + 2 * handshakes));
        handshakes++;
      end
      tick();
      budget--;
    end
    checkOutput("handshakes", 32'(handshakes), 32'(n));
    checkOutput("donePulse", 32'(done), 32'(1));
    if (checkTiming)
      checkOutput("doneCycle", 32'(cyc - startCyc), 32'(2 * n + 1));
    tick();
    checkOutput("doneCleared", 32'(done), 32'(0));
    checkOutput("idleAfterDone", 32'(busy), 32'(0));
  endtask

  initial begin
    bankWords[0] = 32'h44332211;
    bankWords[1] = 32'h88776655;
    bankWords[2] = 32'hCCBBAA99;
    bankWords[3] = 32'h10FFEEDD;
    for (int b = 0; b < 4; b++) banks[b] = bankWords[b];

    rst_n      = 1'b0;
    start      = 1'b0;
    start_addr = '0;
    len        = '0;
    abort      = 1'b0;
    out_ready  = 1'b1;
    #1;
    checkOutput("rstValid", 32'(out_valid), 32'(0));
    checkOutput("rstData", 32'(out_data), 32'(0));
    checkOutput("rstBusy", 32'(busy), 32'(0));
    checkOutput("rstDone", 32'(done), 32'(0));
    checkOutput("rstSel", 32'({bank_sel, byte_sel}), 32'(0));
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] basic burst");
    applyStimulus(4'h0, 5'd4);
    checkOutput("fetchNotValid", 32'(out_valid), 32'(0));
    checkOutput("busyInFetch", 32'(busy), 32'(1));
    drainBurst(4, 1'b1);
    checkOutput("selHoldsInIdle", 32'({bank_sel, byte_sel}), 32'(3));

    $display("[TB] wrap burst");
    applyStimulus(4'hE, 5'd4);
    drainBurst(4, 1'b1);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(4'h5, 5'd2);
    tick();
    checkOutput("bpValid", 32'(out_valid), 32'(1));
    heldData = out_data;
    heldSel  = {bank_sel, byte_sel};
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("bpValidStable", 32'(out_valid), 32'(1));
      checkOutput("bpDataStable", 32'(out_data), 32'(heldData));
      checkOutput("bpSelStable", 32'({bank_sel, byte_sel}), 32'(heldSel));
    end
    out_ready = 1'b1;
    drainBurst(2, 1'b0);

    $display("[TB] abort in second hold");
    start      = 1'b1;
    start_addr = 4'h0;
    len        = 5'd8;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("abortSecondHold", 32'(out_valid), 32'(1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abortValid", 32'(out_valid), 32'(0));
    checkOutput("abortBusy", 32'(busy), 32'(0));
    checkOutput("abortNoDone", 32'(done), 32'(0));
    tick();
    checkOutput("abortStillNoDone", 32'(done), 32'(0));
    applyStimulus(4'h9, 5'd3);
    drainBurst(3, 1'b1);

    $display("[TB] corner cases");
    start      = 1'b1;
    start_addr = 4'h4;
    len        = 5'd0;
    tick();
    start = 1'b0;
    checkOutput("len0Busy", 32'(busy), 32'(0));
    tick();
    checkOutput("len0StillIdle", 32'(busy), 32'(0));

    start = 1'b1;
    abort = 1'b1;
    start_addr = 4'h4;
    len        = 5'd3;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checkOutput("startAbortIdle", 32'(busy), 32'(0));

    applyStimulus(4'h0, 5'd2);
    start      = 1'b1;
    start_addr = 4'h8;
    len        = 5'd5;
    tick();
    start = 1'b0;
    drainBurst(2, 1'b1);

    applyStimulus(4'h3, 5'd16);
    drainBurst(16, 1'b1);

    $display("[TB] reset mid-hold");
    out_ready = 1'b0;
    applyStimulus(4'h7, 5'd4);
    tick();
    checkOutput("preResetValid", 32'(out_valid), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("asyncValid", 32'(out_valid), 32'(0));
    checkOutput("asyncData", 32'(out_data), 32'(0));
    checkOutput("asyncBusy", 32'(busy), 32'(0));
    checkOutput("asyncDone", 32'(done), 32'(0));
    checkOutput("asyncSel", 32'({bank_sel, byte_sel}), 32'(0));
    sb.delete();
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    checkOutput("postResetIdle", 32'(busy), 32'(0));
    checkOutput("postResetValid", 32'(out_valid), 32'(0));
    applyStimulus(4'hB, 5'd3);
    drainBurst(3, 1'b1);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
